shift_register_scheduler: RTL and testbench

Shares one 24-bit serial shift-register writer between N_REQ requesters, e.g. bias DAC, channel-select and LED-latch owners. Round-robin arbitration picks one request and holds its word stable on sr_word. It asserts sr_load until the writer reports sr_done, then drops sr_load for a guard gap and acknowledges the requester. The block sits between the system logic and the serializer, and the serializer's clock domain is the same as clk.

---
 rtl/shift_register_scheduler_pkg.sv | 15 +
 rtl/shift_register_scheduler_if.sv | 15 +
 rtl/shift_register_scheduler_rr_arbiter.sv | 33 +++
 rtl/shift_register_scheduler.sv | 128 ++++++++++++
 tb/tb_shift_register_scheduler.sv | 333 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/shift_register_scheduler_pkg.sv
// rtl/shift_register_scheduler_pkg.sv - shared constants and FSM encoding for the shift register scheduler
package shift_register_scheduler_pkg;

    localparam int WORD_W_DEF     = 24;
    // Worst-case writer latency at 24 bits; TIMEOUT has to clear it.
    localparam int WRITER_LAT_MAX = 80;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_GAP  = 2'd2,
        ST_ACK  = 2'd3
    } state_t;

endpackage

// File: rtl/shift_register_scheduler_if.sv
// rtl/shift_register_scheduler_if.sv - load/word/done handshake between scheduler and serial writer
interface shift_register_scheduler_if
    import shift_register_scheduler_pkg::*;
#(
    parameter int WORD_W = WORD_W_DEF
) ();

    logic              sr_load;
    logic [WORD_W-1:0] sr_word;
    logic              sr_done;

    modport master (output sr_load, output sr_word, input  sr_done);
    modport slave  (input  sr_load, input  sr_word, output sr_done);

endinterface

// File: rtl/shift_register_scheduler_rr_arbiter.sv
// rtl/shift_register_scheduler_rr_arbiter.sv - combinational round-robin pick starting at ptr
module shift_register_scheduler_rr_arbiter #(
    parameter int N_REQ = 4,
    parameter int IDX_W = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N_REQ-1:0] grant,
    output logic [IDX_W-1:0] grant_idx,
    output logic             valid
);

    logic             found;
    logic [IDX_W-1:0] idx;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        idx       = '0;
        for (int k = 0; k < N_REQ; k++) begin
            idx = IDX_W'((int'(ptr) + k) % N_REQ);
            if (!found && req[idx]) begin
                found      = 1'b1;
                grant[idx] = 1'b1;
                grant_idx  = idx;
            end
        end
    end

    assign valid = |req;

endmodule

// File: rtl/shift_register_scheduler.sv
// rtl/shift_register_scheduler.sv - round-robin sharing of one serial writer; SR_SKIP_SAME_EN skips redundant rewrites
module shift_register_scheduler
    import shift_register_scheduler_pkg::*;
#(
    parameter int N_REQ   = 4,
    parameter int WORD_W  = WORD_W_DEF,
    parameter int GAP     = 2,
    parameter int TIMEOUT = 255
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [N_REQ-1:0]          req,
    input  logic [N_REQ*WORD_W-1:0]   word_in,
    output logic [N_REQ-1:0]          ack,
    output logic                      err,
    output logic                      busy,
    output logic [$clog2(N_REQ)-1:0]  grant_id,
    shift_register_scheduler_if.master wr
);

    localparam int IDX_W   = $clog2(N_REQ);
    localparam int CNT_MAX = (TIMEOUT > GAP) ? TIMEOUT : GAP;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    generate
        if (GAP < 1 || TIMEOUT <= WRITER_LAT_MAX) begin : g_bad_cfg
            $error("shift_register_scheduler: GAP must be >= 1 and TIMEOUT must exceed writer latency");
        end
    endgenerate

    state_t            state, next_state;
    logic [CNT_W-1:0]  cnt;
    logic [IDX_W-1:0]  ptr;
    logic [WORD_W-1:0] sr_word_q;
    logic              sr_load_c;
    logic [N_REQ-1:0]  arb_grant;
    logic [IDX_W-1:0]  arb_idx;
    logic              arb_valid;
    logic [WORD_W-1:0] arb_word;
    logic              timeout_hit;

    shift_register_scheduler_rr_arbiter #(.N_REQ(N_REQ), .IDX_W(IDX_W)) u_arb (
        .req       (req),
        .ptr       (ptr),
        .grant     (arb_grant),
        .grant_idx (arb_idx),
        .valid     (arb_valid)
    );

    // One-hot AND-OR mux of the granted requester's word.
    always_comb begin
        arb_word = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (arb_grant[i]) arb_word = arb_word | word_in[i*WORD_W +: WORD_W];
        end
    end

    assign timeout_hit = (cnt == CNT_W'(TIMEOUT - 1)) && !wr.sr_done;

`ifdef SR_SKIP_SAME_EN
    logic [WORD_W-1:0] last_word;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)                            last_word <= '0;
        else if (state == ST_LOAD && wr.sr_done) last_word <= sr_word_q;
    end
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= ST_IDLE;
        else      state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE: begin
                if (arb_valid) begin
                    next_state = ST_LOAD;
`ifdef SR_SKIP_SAME_EN
                    if (arb_word == last_word && !err) next_state = ST_ACK;
`endif
                end
            end
            ST_LOAD: if (wr.sr_done || timeout_hit)    next_state = ST_GAP;
            ST_GAP:  if (cnt == CNT_W'(GAP - 1))       next_state = ST_ACK;
            ST_ACK:  next_state = ST_IDLE;
            default: next_state = ST_IDLE;
        endcase
    end

    always_comb begin
        sr_load_c = 1'b0;
        busy      = 1'b1;
        ack       = '0;
        case (state)
            ST_IDLE: busy = 1'b0;
            ST_LOAD: sr_load_c = 1'b1;
            ST_ACK:  ack[grant_id] = 1'b1;
            default: ;
        endcase
    end

    // Shared counter: LOAD timeout and GAP length, cleared on every state change.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt       <= '0;
            ptr       <= '0;
            sr_word_q <= '0;
            grant_id  <= '0;
            err       <= 1'b0;
        end else begin
            if (state == next_state && (state == ST_LOAD || state == ST_GAP)) cnt <= cnt + 1'b1;
            else                                                              cnt <= '0;
            if (state == ST_IDLE && arb_valid) begin
                sr_word_q <= arb_word;
                grant_id  <= arb_idx;
            end
            if (state == ST_LOAD && timeout_hit) err <= 1'b1;
            if (state == ST_ACK)
                ptr <= (grant_id == IDX_W'(N_REQ - 1)) ? '0 : grant_id + 1'b1;
        end
    end

    assign wr.sr_load = sr_load_c;
    assign wr.sr_word = sr_word_q;

endmodule

// File: tb/tb_shift_register_scheduler.sv
// tb/tb_shift_register_scheduler.sv - directed and randomized checks against a timeline model of the scheduler
module tb_shift_register_scheduler;

    localparam int N   = 4;
    localparam int W   = 24;
    localparam int GAP = 2;
    localparam int TO  = 255;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic [N-1:0]   req = '0;
    logic [N*W-1:0] word_in = '0;
    logic [N-1:0]   ack;
    logic           err, busy;
    logic [1:0]     grant_id;
    logic           sr_done = 1'b0;

    always #5 clk = ~clk;

    shift_register_scheduler_if #(.WORD_W(W)) wr_if ();
    assign wr_if.sr_done = sr_done;

    shift_register_scheduler #(.N_REQ(N), .WORD_W(W), .GAP(GAP), .TIMEOUT(TO)) dut (
        .clk      (clk),
        .rst      (rst_n),
        .req      (req),
        .word_in  (word_in),
        .ack      (ack),
        .err      (err),
        .busy     (busy),
        .grant_id (grant_id),
        .wr       (wr_if)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Stimulus control
    bit           auto_req = 1'b0;
    bit           hang = 1'b0;
    bit           spurious = 1'b0;
    int           wlat_fixed = 0;
    logic [N-1:0] dir_req = '0;
    logic [W-1:0] dir_word [N];
    logic [N-1:0] ack_seen = '0;

    function automatic logic [W-1:0] rand_word();
        if ($urandom % 4 == 0) return W'($urandom % 3);
        return W'($urandom);
    endfunction

    // Requester side: sole driver of req and word_in.
    always @(posedge clk) begin
        #2;
        if (auto_req) begin
            for (int i = 0; i < N; i++) begin
                if (req[i] && ack_seen[i]) req[i] = ($urandom % 3 == 0);
                else if (!req[i] && $urandom % 6 == 0) begin
                    req[i] = 1'b1;
                    word_in[i*W +: W] = rand_word();
                end else if (req[i] && $urandom % 150 == 0) req[i] = 1'b0;
                if ($urandom % 20 == 0) word_in[i*W +: W] = rand_word();
            end
        end else begin
            req = dir_req;
            for (int i = 0; i < N; i++) word_in[i*W +: W] = dir_word[i];
        end
    end

    // Serial writer: done after wlat load cycles, held until load drops.
    int wcnt = 0;
    int wlat = 1;
    always @(posedge clk) begin
        #1;
        if (wr_if.sr_load) begin
            wcnt++;
            if (wcnt == 1) wlat = (wlat_fixed > 0) ? wlat_fixed : $urandom_range(1, 20);
            sr_done = !hang && (wcnt >= wlat);
        end else begin
            wcnt = 0;
            sr_done = spurious && ($urandom % 4 == 0);
        end
    end

    // Timeline model: each grant fixes load start, load end is set by done or timeout,
    // ack follows GAP cycles later, and the next grant may only come after the ack.
    int           cyc = 0;
    bit           m_act = 0, m_fix = 0, m_skip = 0, m_toerr = 0, m_err = 0;
    int           m_ls = 0, m_le = 0, m_ackt = 0, m_g = 0, m_ptr = 0, m_gid = 0;
    logic [W-1:0] m_w = '0, m_last = '0;
    logic         el;
    logic [N-1:0] ea;
    bit           eerr;

    int           ack_q[$];
    int           run_q[$];
    int           gap_q[$];
    int           run = 0, fall_cyc = 0;
    logic [W-1:0] load_word = '0;
    logic         prev_load = 1'b0;

    always @(negedge clk) begin
        cyc++;
        ack_seen = ack;
        if (!rst_n) begin
            m_act = 0; m_err = 0; m_toerr = 0; m_ptr = 0; m_gid = 0; m_last = '0;
            prev_load = 1'b0; run = 0;
        end else begin
            if (m_act && !m_skip && !m_fix && cyc >= m_ls) begin
                if (sr_done) begin
                    m_le = cyc; m_fix = 1; m_ackt = cyc + GAP + 1; m_last = m_w;
                end else if (cyc == m_ls + TO - 1) begin
                    m_le = cyc; m_fix = 1; m_ackt = cyc + GAP + 1; m_toerr = 1;
                end
            end
            el   = m_act && !m_skip && cyc >= m_ls && (!m_fix || cyc <= m_le);
            ea   = (m_act && m_fix && cyc == m_ackt) ? (N'(1) << m_g) : '0;
            eerr = m_err || (m_toerr && cyc > m_le);
            if (m_act && cyc == m_ls) m_gid = m_g;

            check("sr_load", wr_if.sr_load, el);
            check("ack", ack, ea);
            check("busy", busy, m_act && cyc >= m_ls);
            check("err", err, eerr);
            check("grant_id", grant_id, m_gid);
            if (el) check("sr_word", wr_if.sr_word, m_w);

            if (m_act) begin
                if (m_fix && cyc == m_ackt) begin
                    m_act = 0; m_ptr = (m_g + 1) % N; m_err = eerr; m_toerr = 0;
                end
            end else if (req != '0) begin
                for (int k = N - 1; k >= 0; k--)
                    if (req[2'((m_ptr + k) % N)]) m_g = (m_ptr + k) % N;
                m_w = word_in[m_g*W +: W];
                m_ls = cyc + 1; m_act = 1; m_fix = 0; m_skip = 0;
`ifdef SR_SKIP_SAME_EN
                if (m_w == m_last && !eerr) begin
                    m_skip = 1; m_fix = 1; m_ackt = cyc + 1;
                end
`endif
            end

            if (wr_if.sr_load) begin
                run = prev_load ? run + 1 : 1;
                load_word = wr_if.sr_word;
            end else if (prev_load) begin
                run_q.push_back(run);
                fall_cyc = cyc;
            end
            prev_load = wr_if.sr_load;
            if (ack != '0) begin
                for (int k = 0; k < N; k++) if (ack[k]) ack_q.push_back(k);
                gap_q.push_back(cyc - fall_cyc);
            end
        end
    end

    task automatic clear_logs();
        ack_q.delete(); run_q.delete(); gap_q.delete();
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst_n = 1'b0; dir_req = '0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        clear_logs();
    endtask

    task automatic wait_ack(input string name, input int limit);
        int c;
        c = 0;
        do begin
            @(negedge clk);
            c++;
        end while (ack == '0 && c < limit);
        check({name, "_ack_seen"}, ack != '0, 1);
    endtask

    task automatic set_req(input logic [N-1:0] r);
        @(posedge clk); #1 dir_req = r;
    endtask

    initial begin
        for (int i = 0; i < N; i++) dir_word[i] = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_ack", ack, 0);
        check("rst_err", err, 0);
        check("rst_busy", busy, 0);
        check("rst_grant_id", grant_id, 0);
        check("rst_sr_load", wr_if.sr_load, 0);
        check("rst_sr_word", wr_if.sr_word, 0);
        @(posedge clk); #1 rst_n = 1'b1;

        // Single request with a 10-cycle writer
        wlat_fixed = 10;
        dir_word[0] = 24'hA5A5A5;
        dir_req = 4'b0001;
        wait_ack("single", 100);
        check("single_ack", ack, 4'b0001);
        set_req(4'b0000);
        repeat (4) @(negedge clk);
        check("single_ack_count", ack_q.size(), 1);
        check("single_load_len", run_q[0], 10);
        check("single_gap", gap_q[0], GAP);
        check("single_word", load_word, 24'hA5A5A5);
        check("single_err", err, 0);

        // Contention: all four held
        do_reset();
        wlat_fixed = 0;
        for (int i = 0; i < N; i++) dir_word[i] = W'(24'h111111 * (i + 1));
        dir_req = 4'b1111;
        for (int i = 0; i < 5; i++) wait_ack("contention", 200);
        set_req(4'b0000);
        check("cont_ack_count", ack_q.size(), 5);
        for (int i = 0; i < 5; i++) check("cont_order", ack_q[i], i % 4);
        for (int i = 0; i < 5; i++) check("cont_gap_min", gap_q[i] >= 2, 1);

        // Wrap: serve 2, then 3 must beat 0
        do_reset();
        dir_req = 4'b0100;
        wait_ack("wrap_first", 100);
        set_req(4'b1001);
        wait_ack("wrap_second", 100);
        set_req(4'b0001);
        wait_ack("wrap_third", 100);
        set_req(4'b0000);
        check("wrap_count", ack_q.size(), 3);
        check("wrap_order0", ack_q[0], 2);
        check("wrap_order1", ack_q[1], 3);
        check("wrap_order2", ack_q[2], 0);

        // Timeout on requester 1, then a normal transfer still goes through
        clear_logs();
        hang = 1'b1;
        set_req(4'b0010);
        wait_ack("timeout", 400);
        check("timeout_ack", ack, 4'b0010);
        check("timeout_err", err, 1);
        check("timeout_load_len", run_q[0], TO);
        @(posedge clk); #1 dir_req = 4'b0000; hang = 1'b0;
        set_req(4'b0001);
        wait_ack("post_timeout", 100);
        check("post_timeout_ack", ack, 4'b0001);
        check("post_timeout_err_sticky", err, 1);
        set_req(4'b0000);

        // Asynchronous reset in the middle of a transfer
        wlat_fixed = 30;
        set_req(4'b0100);
        begin
            int c;
            c = 0;
            while (!wr_if.sr_load && c < 50) begin
                @(negedge clk);
                c++;
            end
        end
        check("areset_load_seen", wr_if.sr_load, 1);
        repeat (5) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        check("areset_sr_load", wr_if.sr_load, 0);
        check("areset_busy", busy, 0);
        check("areset_ack", ack, 0);
        check("areset_err", err, 0);
        @(posedge clk); #1 rst_n = 1'b1;
        clear_logs();
        wait_ack("areset_restart", 100);
        check("areset_restart_ack", ack, 4'b0100);
        set_req(4'b0000);

`ifdef SR_SKIP_SAME_EN
        do_reset();
        wlat_fixed = 5;
        dir_word[2] = 24'h00FF00;
        dir_req = 4'b0100;
        wait_ack("skip_first", 100);
        set_req(4'b0000);
        set_req(4'b0100);
        wait_ack("skip_second", 100);
        set_req(4'b0000);
        check("skip_after_two", run_q.size(), 1);
        @(posedge clk); #1 dir_word[2] = 24'h00FF01; dir_req = 4'b0100;
        wait_ack("skip_third", 100);
        set_req(4'b0000);
        check("skip_after_change", run_q.size(), 2);
        check("skip_ack_count", ack_q.size(), 3);
`endif

        // Randomized traffic with spurious done pulses
        do_reset();
        wlat_fixed = 0;
        spurious = 1'b1;
        auto_req = 1'b1;
        repeat (4000) @(posedge clk);
        #1 auto_req = 1'b0; dir_req = '0;
        begin
            int c;
            c = 0;
            do begin
                @(negedge clk);
                c++;
            end while ((busy || req != '0) && c < 400);
        end
        check("rand_drained", busy, 0);
        check("rand_activity", ack_q.size() > 20, 1);
        spurious = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        errors++;
        $display("FAIL watchdog: simulation did not complete, time %0t limit 1000000", $time);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
